decode_stage: RTL and testbench
===============================

# decode_stage

Pipelined RV32 instruction-decode stage with a valid/ready handshake on both sides, a two-entry skid buffer and a registered output. It decodes all six instruction formats, including correct J-type and B-type immediates, and validates register-operand usage. It flags illegal encodings and optionally recognises the M extension. It sits between the fetch stage and register-file read/execute, and supersedes the purely combinational decoder.

## Interface
- `XLEN`, 32: width of the PC carried alongside each instruction.
- `ENABLE_M`, 0: 1 makes OP with funct7=0000001 legal and asserts `out_is_mext`.
- `SKID`, 1: 1 gives a two-entry skid and `in_ready` driven from registers only; 0 gives a single entry with `in_ready = out_ready | ~out_valid`.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous kill of all buffered instructions.
- `in_valid` in 1; `in_ready` out 1; `in_instr` in 32; `in_pc` in XLEN.
- `out_valid` out 1; `out_ready` in 1; `out_pc` out XLEN.
- `out_rs1`, `out_rs2`, `out_rd` out 5 each: raw fields instr[19:15], [24:20], [11:7].
- `out_rs1_valid`, `out_rs2_valid`, `out_rd_valid` out 1 each.
- `out_imm` out 32: sign-extended immediate.
- `out_fmt` out 3: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=none.
- `out_dec_bits` out 11: {instr[30], funct3, opcode}.
- `out_illegal` out 1; `out_is_mext` out 1.

## Operation
- Decode is combinational on `in_instr` and is captured with the PC on acceptance (`in_valid & in_ready`).
- Legal opcodes are LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, MISC-MEM 0001111 and SYSTEM 1110011.
- Illegal conditions:
  - instr[1:0] != 11, or any other opcode;
  - JALR with funct3 != 000;
  - BRANCH with funct3 010 or 011;
  - LOAD with funct3 011, 110 or 111;
  - STORE with funct3 >= 011;
  - OP-IMM shift with funct7 not in {0000000, 0100000}, or 0100000 paired with SLLI;
  - OP with funct7 not in {0000000, 0100000 (funct3 000/101 only), 0000001 (only if `ENABLE_M`)}.
- An illegal instruction still propagates with `out_illegal`=1, `out_fmt`=7, all `*_valid`=0 and `out_imm`=0.
- Immediates:
  - I: {20{i31}, i31:20}
  - S: {20{i31}, i31:25, i11:7}
  - B: {19{i31}, i31, i7, i30:25, i11:8, 0}
  - U: {i31:12, 12'b0}
  - J: {11{i31}, i31, i19:12, i20, i30:21, 0}
  - R: 0
- `rs1_valid` for R/I/S/B; `rs2_valid` for R/S/B; `rd_valid` for R/I/U/J and rd != 0.
- MISC-MEM and SYSTEM decode as I.
- Skid (`SKID`=1):
  - Output register O and skid register K.
  - When O is full and `out_ready`=0, an accepted beat goes to K.
  - When O drains, K moves to O.
  - `in_ready` (registered) = ~K_valid.
  - Order is always preserved.
- `flush`:
  - Clears O_valid and K_valid at the edge.
  - Forces `in_ready`=0 in that cycle, so a beat offered during flush is not accepted.
  - `flush` has priority over all handshakes.
- `rst` behaves as `flush` and additionally zeroes all data registers.

## Timing
- Reset values: `out_valid`=0, all data outputs 0, `out_fmt`=0.
- `in_ready` is 0 while `rst`=1 and 1 in the first cycle after release.
- Latency: a beat accepted at edge n is presented with `out_valid`=1 after edge n.
- Throughput: 1 instruction/cycle with `out_ready` held high.
- Outputs hold stable while `out_valid & ~out_ready`.
- Stall: with O and K full, `in_ready`=0 starting the cycle after K fills.
- After `out_ready` returns: O←K at the next transfer edge, and `in_ready` rises the following cycle.
- Simultaneous accept and drain with K empty: the new beat loads O directly with no bubble.
- `rst` or `flush` mid-stall drops both entries; the next accepted beat gets latency 1.
- With `SKID`=0 there is no K; `in_ready` is combinational from `out_ready`.

## Test plan
- **I-type:** 0xFFF00093 (addi x1,x0,-1) -> imm 0xFFFFFFFF, rd 1, rd_valid 1, rs1 0, rs1_valid 1, fmt 1, one cycle later.
- **J-type and B-type:**
  - 0x001000EF -> imm 0x00000800, rd 1, fmt 5.
  - 0xFE208EE3 (beq x1,x2,-4) -> imm 0xFFFFFFFC, rs1 1, rs2 2, rd_valid 0.
- **M extension:** 0x022081B3 (mul) -> `ENABLE_M`=0 gives illegal 1, all valids 0; `ENABLE_M`=1 gives is_mext 1, fmt 0.
- **Backpressure:** 4 back-to-back beats with `out_ready`=0 for 3 cycles -> `in_ready` drops after 2 acceptances; all 4 emerge in order with none lost or duplicated.
- **Flush mid-stall:** flush with O and K full plus a beat offered -> next cycle `out_valid`=0 and that beat is not accepted; a new beat appears 1 cycle after its acceptance.
- **Reset and illegal:** `rst` asserted mid-stream -> outputs return to reset values. 0x00000000 -> illegal 1, fmt 7, imm 0.

Source files
------------

// File: rtl/decode_stage_if.sv
// decode_stage_if: valid/ready bundle between fetch and the decode stage and
// between the decode stage and register-file read/execute.
//   in_*  : fetch-side beat (in_valid/in_ready handshake, instruction + PC)
//   out_* : decoded beat (out_valid/out_ready handshake, decoded fields)
// Modports: master = fetch/consumer side (drives in_* and out_ready),
//           slave  = decode stage.
interface decode_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_rs1_valid;
  logic            out_rs2_valid;
  logic            out_rd_valid;
  logic [31:0]     out_imm;
  logic [2:0]      out_fmt;
  logic [10:0]     out_dec_bits;
  logic            out_illegal;
  logic            out_is_mext;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
           out_rs1_valid, out_rs2_valid, out_rd_valid, out_imm, out_fmt,
           out_dec_bits, out_illegal, out_is_mext
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
           out_rs1_valid, out_rs2_valid, out_rd_valid, out_imm, out_fmt,
           out_dec_bits, out_illegal, out_is_mext
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: pipelined RV32 instruction decode with valid/ready on both
// sides, an output register O and (SKID=1) a skid register K.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (kills beats, zeroes data regs)
//   flush : synchronous kill of all buffered beats
//   bus   : decode_stage_if.slave (in_* from fetch, out_* decoded beat)
// Parameters: XLEN (PC width), ENABLE_M (accept M extension),
//             SKID (1 = two entries with registered in_ready, 0 = one entry).
module decode_stage #(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b0,
  parameter bit          SKID     = 1'b1
) (
  input logic           clk,
  input logic           rst,
  input logic           flush,
  decode_stage_if.slave bus
);

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  typedef enum logic [6:0] {
    OPC_LUI      = 7'b0110111,
    OPC_AUIPC    = 7'b0010111,
    OPC_JAL      = 7'b1101111,
    OPC_JALR     = 7'b1100111,
    OPC_BRANCH   = 7'b1100011,
    OPC_LOAD     = 7'b0000011,
    OPC_STORE    = 7'b0100011,
    OPC_OP_IMM   = 7'b0010011,
    OPC_OP       = 7'b0110011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_SYSTEM   = 7'b1110011
  } opc_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1_valid;
    logic            rs2_valid;
    logic            rd_valid;
    logic [31:0]     imm;
    fmt_e            fmt;
    logic [10:0]     dec_bits;
    logic            illegal;
    logic            is_mext;
  } beat_t;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  logic  illegal_c;
  logic  mext_c;
  fmt_e  fmt_c;
  beat_t dec_c;

  beat_t o_q, o_d;
  beat_t k_q, k_d;
  logic  o_valid_q, o_valid_d;
  logic  k_valid_q, k_valid_d;

  logic  in_ready_c;
  logic  accept;
  logic  drain;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Format and legality from opcode/funct fields.
  always_comb begin
    illegal_c = 1'b0;
    mext_c    = 1'b0;
    fmt_c     = FMT_NONE;
    case (opcode)
      OPC_LUI, OPC_AUIPC: fmt_c = FMT_U;
      OPC_JAL:            fmt_c = FMT_J;
      OPC_JALR: begin
        fmt_c     = FMT_I;
        illegal_c = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        fmt_c     = FMT_B;
        illegal_c = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        fmt_c     = FMT_I;
        illegal_c = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        fmt_c     = FMT_S;
        illegal_c = (funct3 >= 3'b011);
      end
      OPC_OP_IMM: begin
        fmt_c = FMT_I;
        if (funct3 == 3'b001)
          illegal_c = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101)
          illegal_c = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OPC_OP: begin
        fmt_c = FMT_R;
        if (funct7 == 7'b0000000)
          illegal_c = 1'b0;
        else if (funct7 == 7'b0100000)
          illegal_c = (funct3 != 3'b000) && (funct3 != 3'b101);
        else if ((funct7 == 7'b0000001) && ENABLE_M)
          mext_c = 1'b1;
        else
          illegal_c = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: fmt_c = FMT_I;
      default: illegal_c = 1'b1;
    endcase
  end

  // Full decoded beat; an illegal encoding keeps its raw fields but carries
  // no format, immediate or operand-valid information.
  always_comb begin
    dec_c          = '0;
    dec_c.pc       = bus.in_pc;
    dec_c.rs1      = instr[19:15];
    dec_c.rs2      = instr[24:20];
    dec_c.rd       = instr[11:7];
    dec_c.dec_bits = {instr[30], funct3, opcode};
    if (illegal_c) begin
      dec_c.illegal = 1'b1;
      dec_c.fmt     = FMT_NONE;
    end else begin
      dec_c.fmt     = fmt_c;
      dec_c.is_mext = mext_c;
      case (fmt_c)
        FMT_I:   dec_c.imm = {{20{instr[31]}}, instr[31:20]};
        FMT_S:   dec_c.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        FMT_B:   dec_c.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
        FMT_U:   dec_c.imm = {instr[31:12], 12'b0};
        FMT_J:   dec_c.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
        default: dec_c.imm = '0;
      endcase
      dec_c.rs1_valid = (fmt_c == FMT_R) || (fmt_c == FMT_I) ||
                        (fmt_c == FMT_S) || (fmt_c == FMT_B);
      dec_c.rs2_valid = (fmt_c == FMT_R) || (fmt_c == FMT_S) || (fmt_c == FMT_B);
      dec_c.rd_valid  = ((fmt_c == FMT_R) || (fmt_c == FMT_I) ||
                         (fmt_c == FMT_U) || (fmt_c == FMT_J)) &&
                        (instr[11:7] != 5'd0);
    end
  end

  // With SKID, readiness depends only on K occupancy; rst/flush gate it so a
  // beat offered while the pipe is being killed is never taken.
  always_comb begin
    if (SKID)
      in_ready_c = ~k_valid_q & ~flush & ~rst;
    else
      in_ready_c = (bus.out_ready | ~o_valid_q) & ~flush & ~rst;
  end

  assign accept = bus.in_valid & in_ready_c;
  assign drain  = o_valid_q & bus.out_ready;

  // O refills from K first (oldest beat) so order is preserved; a new beat
  // only lands in K when O is holding and not draining.
  always_comb begin
    o_d       = o_q;
    k_d       = k_q;
    o_valid_d = o_valid_q;
    k_valid_d = k_valid_q;
    if (drain || !o_valid_q) begin
      if (k_valid_q) begin
        o_d       = k_q;
        o_valid_d = 1'b1;
        k_valid_d = 1'b0;
      end else if (accept) begin
        o_d       = dec_c;
        o_valid_d = 1'b1;
      end else begin
        o_valid_d = 1'b0;
      end
    end else if (accept) begin
      k_d       = dec_c;
      k_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid_q <= 1'b0;
      k_valid_q <= 1'b0;
      o_q       <= '0;
      k_q       <= '0;
    end else if (flush) begin
      o_valid_q <= 1'b0;
      k_valid_q <= 1'b0;
    end else begin
      o_valid_q <= o_valid_d;
      k_valid_q <= k_valid_d;
      o_q       <= o_d;
      k_q       <= k_d;
    end
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.out_valid     = o_valid_q;
  assign bus.out_pc        = o_q.pc;
  assign bus.out_rs1       = o_q.rs1;
  assign bus.out_rs2       = o_q.rs2;
  assign bus.out_rd        = o_q.rd;
  assign bus.out_rs1_valid = o_q.rs1_valid;
  assign bus.out_rs2_valid = o_q.rs2_valid;
  assign bus.out_rd_valid  = o_q.rd_valid;
  assign bus.out_imm       = o_q.imm;
  assign bus.out_fmt       = o_q.fmt;
  assign bus.out_dec_bits  = o_q.dec_bits;
  assign bus.out_illegal   = o_q.illegal;
  assign bus.out_is_mext   = o_q.is_mext;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic clk;
  logic rst;
  logic flush;

  int checks;
  int errors;

  decode_stage_if #(.XLEN(32)) bif0 ();
  decode_stage_if #(.XLEN(32)) bif1 ();

  decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .SKID(1'b1)) u_dut0 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bif0.slave)
  );

  decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .SKID(1'b1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bif1.slave)
  );

  assign bif1.in_valid  = bif0.in_valid;
  assign bif1.in_instr  = bif0.in_instr;
  assign bif1.in_pc     = bif0.in_pc;
  assign bif1.out_ready = bif0.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [2:0]  vld;    // {rs1_valid, rs2_valid, rd_valid}
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [10:0] dec;
    logic        m_ill;  // expectations for the ENABLE_M=1 instance
    logic [2:0]  m_fmt;
    logic        m_mext;
  } vec_t;

  vec_t vecs [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] got_pc [$];
  int          sent;
  logic        acc;
  logic [1:0]  exp_rdy [6];

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 3'b101, 5'd0,  5'd31, 5'd1,  11'h413, 1'b0, 3'd1, 1'b0};
    vecs[1]  = '{32'h001000EF, 32'h00000800, 3'd5, 1'b0, 3'b001, 5'd0,  5'd1,  5'd1,  11'h06F, 1'b0, 3'd5, 1'b0};
    vecs[2]  = '{32'hFE208EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 3'b110, 5'd1,  5'd2,  5'd29, 11'h463, 1'b0, 3'd3, 1'b0};
    vecs[3]  = '{32'h022081B3, 32'h00000000, 3'd7, 1'b1, 3'b000, 5'd1,  5'd2,  5'd3,  11'h033, 1'b0, 3'd0, 1'b1};
    vecs[4]  = '{32'h00000000, 32'h00000000, 3'd7, 1'b1, 3'b000, 5'd0,  5'd0,  5'd0,  11'h000, 1'b1, 3'd7, 1'b0};
    vecs[5]  = '{32'h002081B3, 32'h00000000, 3'd0, 1'b0, 3'b111, 5'd1,  5'd2,  5'd3,  11'h033, 1'b0, 3'd0, 1'b0};
    vecs[6]  = '{32'h402081B3, 32'h00000000, 3'd0, 1'b0, 3'b111, 5'd1,  5'd2,  5'd3,  11'h433, 1'b0, 3'd0, 1'b0};
    vecs[7]  = '{32'h402091B3, 32'h00000000, 3'd7, 1'b1, 3'b000, 5'd1,  5'd2,  5'd3,  11'h4B3, 1'b1, 3'd7, 1'b0};
    vecs[8]  = '{32'h123452B7, 32'h12345000, 3'd4, 1'b0, 3'b001, 5'd8,  5'd3,  5'd5,  11'h2B7, 1'b0, 3'd4, 1'b0};
    vecs[9]  = '{32'h0020A423, 32'h00000008, 3'd2, 1'b0, 3'b110, 5'd1,  5'd2,  5'd8,  11'h123, 1'b0, 3'd2, 1'b0};
    vecs[10] = '{32'hFE20AFA3, 32'hFFFFFFFF, 3'd2, 1'b0, 3'b110, 5'd1,  5'd2,  5'd31, 11'h523, 1'b0, 3'd2, 1'b0};
    vecs[11] = '{32'h000010E7, 32'h00000000, 3'd7, 1'b1, 3'b000, 5'd0,  5'd0,  5'd1,  11'h0E7, 1'b1, 3'd7, 1'b0};
    vecs[12] = '{32'h00008067, 32'h00000000, 3'd1, 1'b0, 3'b100, 5'd1,  5'd0,  5'd0,  11'h067, 1'b0, 3'd1, 1'b0};
    vecs[13] = '{32'h00109093, 32'h00000001, 3'd1, 1'b0, 3'b101, 5'd1,  5'd1,  5'd1,  11'h093, 1'b0, 3'd1, 1'b0};
    vecs[14] = '{32'h40109093, 32'h00000000, 3'd7, 1'b1, 3'b000, 5'd1,  5'd1,  5'd1,  11'h493, 1'b1, 3'd7, 1'b0};
    vecs[15] = '{32'h4010D093, 32'h00000401, 3'd1, 1'b0, 3'b101, 5'd1,  5'd1,  5'd1,  11'h693, 1'b0, 3'd1, 1'b0};
    vecs[16] = '{32'h00002063, 32'h00000000, 3'd7, 1'b1, 3'b000, 5'd0,  5'd0,  5'd0,  11'h163, 1'b1, 3'd7, 1'b0};
    vecs[17] = '{32'h00003003, 32'h00000000, 3'd7, 1'b1, 3'b000, 5'd0,  5'd0,  5'd0,  11'h183, 1'b1, 3'd7, 1'b0};
    vecs[18] = '{32'hFFC12083, 32'hFFFFFFFC, 3'd1, 1'b0, 3'b101, 5'd2,  5'd28, 5'd1,  11'h503, 1'b0, 3'd1, 1'b0};
    vecs[19] = '{32'h00000073, 32'h00000000, 3'd1, 1'b0, 3'b100, 5'd0,  5'd0,  5'd0,  11'h073, 1'b0, 3'd1, 1'b0};
    vecs[20] = '{32'h00000010, 32'h00000000, 3'd7, 1'b1, 3'b000, 5'd0,  5'd0,  5'd0,  11'h010, 1'b1, 3'd7, 1'b0};
    vecs[21] = '{32'h00003023, 32'h00000000, 3'd7, 1'b1, 3'b000, 5'd0,  5'd0,  5'd0,  11'h1A3, 1'b1, 3'd7, 1'b0};
    vecs[22] = '{32'hFFFFF097, 32'hFFFFF000, 3'd4, 1'b0, 3'b001, 5'd31, 5'd31, 5'd1,  11'h797, 1'b0, 3'd4, 1'b0};
    vecs[23] = '{32'hFFFFF06F, 32'hFFFFFFFE, 3'd5, 1'b0, 3'b000, 5'd31, 5'd31, 5'd0,  11'h7EF, 1'b0, 3'd5, 1'b0};

    // ---------------- reset state ----------------
    rst            = 1'b1;
    flush          = 1'b0;
    bif0.in_valid  = 1'b0;
    bif0.in_instr  = '0;
    bif0.in_pc     = '0;
    bif0.out_ready = 1'b0;
    step();
    step();
    step();
    chk("rst_out_valid", {31'd0, bif0.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, bif0.in_ready}, 32'd0);
    chk("rst_out_fmt",   {29'd0, bif0.out_fmt}, 32'd0);
    chk("rst_out_imm",   bif0.out_imm, 32'd0);
    chk("rst_out_pc",    bif0.out_pc, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready",  {31'd0, bif0.in_ready}, 32'd1);

    // ---------------- decode vectors, back-to-back ----------------
    bif0.out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      bif0.in_valid = 1'b1;
      bif0.in_instr = vecs[i].instr;
      bif0.in_pc    = 32'h1000 + 32'(i) * 4;
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'd0, bif0.in_ready}, 32'd1);
      step();
      chk($sformatf("v%0d_valid", i), {31'd0, bif0.out_valid}, 32'd1);
      chk($sformatf("v%0d_pc", i), bif0.out_pc, 32'h1000 + 32'(i) * 4);
      chk($sformatf("v%0d_imm", i), bif0.out_imm, vecs[i].imm);
      chk($sformatf("v%0d_fmt", i), {29'd0, bif0.out_fmt}, {29'd0, vecs[i].fmt});
      chk($sformatf("v%0d_illegal", i), {31'd0, bif0.out_illegal}, {31'd0, vecs[i].ill});
      chk($sformatf("v%0d_valids", i),
          {29'd0, bif0.out_rs1_valid, bif0.out_rs2_valid, bif0.out_rd_valid},
          {29'd0, vecs[i].vld});
      chk($sformatf("v%0d_regs", i), {17'd0, bif0.out_rs1, bif0.out_rs2, bif0.out_rd},
          {17'd0, vecs[i].rs1, vecs[i].rs2, vecs[i].rd});
      chk($sformatf("v%0d_dec_bits", i), {21'd0, bif0.out_dec_bits}, {21'd0, vecs[i].dec});
      chk($sformatf("v%0d_mext", i), {31'd0, bif0.out_is_mext}, 32'd0);
      chk($sformatf("v%0d_m_illegal", i), {31'd0, bif1.out_illegal}, {31'd0, vecs[i].m_ill});
      chk($sformatf("v%0d_m_fmt", i), {29'd0, bif1.out_fmt}, {29'd0, vecs[i].m_fmt});
      chk($sformatf("v%0d_m_mext", i), {31'd0, bif1.out_is_mext}, {31'd0, vecs[i].m_mext});
    end
    bif0.in_valid = 1'b0;
    step();
    chk("drain_empty", {31'd0, bif0.out_valid}, 32'd0);

    // ---------------- flush with O and K full ----------------
    bif0.out_ready = 1'b0;
    bif0.in_valid  = 1'b1;
    bif0.in_instr  = 32'hFFF00093;
    bif0.in_pc     = 32'h5000;
    step();
    bif0.in_pc     = 32'h5004;
    step();
    chk("fl_k_full_in_ready", {31'd0, bif0.in_ready}, 32'd0);
    bif0.in_pc = 32'h5008;
    flush      = 1'b1;
    #1;
    chk("fl_in_ready", {31'd0, bif0.in_ready}, 32'd0);
    step();
    flush = 1'b0;
    chk("fl_out_valid", {31'd0, bif0.out_valid}, 32'd0);
    bif0.in_pc     = 32'h500C;
    bif0.out_ready = 1'b1;
    #1;
    chk("fl_new_in_ready", {31'd0, bif0.in_ready}, 32'd1);
    step();
    chk("fl_new_valid", {31'd0, bif0.out_valid}, 32'd1);
    chk("fl_new_pc", bif0.out_pc, 32'h500C);
    bif0.in_valid = 1'b0;
    step();
    chk("fl_nothing_left", {31'd0, bif0.out_valid}, 32'd0);

    // ---------------- backpressure: 4 beats, out_ready low 3 cycles --------
    exp_rdy[0] = 2'd1;
    exp_rdy[1] = 2'd1;
    exp_rdy[2] = 2'd0;
    exp_rdy[3] = 2'd0;
    exp_rdy[4] = 2'd1;
    exp_rdy[5] = 2'd1;
    sent = 0;
    got_pc.delete();
    for (int c = 0; c < 16; c++) begin
      bif0.out_ready = (c >= 3);
      if (sent < 4) begin
        bif0.in_valid = 1'b1;
        bif0.in_instr = 32'h002081B3;
        bif0.in_pc    = 32'h2000 + 32'(sent) * 4;
      end else begin
        bif0.in_valid = 1'b0;
      end
      #2;
      if (c < 6)
        chk($sformatf("bp_in_ready_c%0d", c), {31'd0, bif0.in_ready}, {30'd0, exp_rdy[c]});
      if (c == 2)
        chk("bp_hold_pc", bif0.out_pc, 32'h2000);
      acc = bif0.in_valid & bif0.in_ready;
      if (bif0.out_valid && bif0.out_ready)
        got_pc.push_back(bif0.out_pc);
      step();
      if (acc)
        sent++;
    end
    chk("bp_count", 32'(got_pc.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_pc.size())
        chk($sformatf("bp_order%0d", i), got_pc[i], 32'h2000 + 32'(i) * 4);
      else
        chk($sformatf("bp_order%0d", i), 32'hDEADDEAD, 32'h2000 + 32'(i) * 4);
    end

    // ---------------- reset mid-stream ----------------
    bif0.out_ready = 1'b0;
    bif0.in_valid  = 1'b1;
    bif0.in_instr  = 32'h123452B7;
    bif0.in_pc     = 32'h3000;
    step();
    bif0.in_pc = 32'h3004;
    step();
    chk("mr_pre_valid", {31'd0, bif0.out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_in_ready_rst", {31'd0, bif0.in_ready}, 32'd0);
    step();
    chk("mr_out_valid", {31'd0, bif0.out_valid}, 32'd0);
    chk("mr_out_pc", bif0.out_pc, 32'd0);
    chk("mr_out_imm", bif0.out_imm, 32'd0);
    chk("mr_out_fmt", {29'd0, bif0.out_fmt}, 32'd0);
    chk("mr_out_regs", {17'd0, bif0.out_rs1, bif0.out_rs2, bif0.out_rd}, 32'd0);
    rst            = 1'b0;
    bif0.in_pc     = 32'h3008;
    bif0.out_ready = 1'b1;
    #1;
    chk("mr_rel_in_ready", {31'd0, bif0.in_ready}, 32'd1);
    step();
    bif0.in_valid = 1'b0;
    chk("mr_new_valid", {31'd0, bif0.out_valid}, 32'd1);
    chk("mr_new_pc", bif0.out_pc, 32'h3008);
    chk("mr_new_imm", bif0.out_imm, 32'h12345000);
    step();
    chk("mr_empty", {31'd0, bif0.out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
